// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants, FSM encoding and point clamp for the score keeper
package score_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Loss message glyphs, digit0..digit3
  localparam logic [DIGIT_W-1:0] MSG_D = 4'hD;
  localparam logic [DIGIT_W-1:0] MSG_1 = 4'h1;
  localparam logic [DIGIT_W-1:0] MSG_E = 4'hE;
  localparam logic [DIGIT_W-1:0] MSG_F = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

  // Point values above nine are treated as nine
  function automatic logic [DIGIT_W-1:0] clamp_pts(input logic [DIGIT_W-1:0] p);
    return (p > BCD_MAX) ? BCD_MAX : p;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - one BCD digit plus a 0..9 carry-in, producing digit and decimal carry
module bcd_digit_step
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic [DIGIT_W-1:0] carry_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               carry_out
);

  // Widest sum is 9 + 9 = 18, so one extra bit is enough
  logic [DIGIT_W:0] sum;

  assign sum       = {1'b0, digit_in} + {1'b0, carry_in};
  assign carry_out = (sum > {1'b0, BCD_MAX});
  assign digit_out = carry_out ? DIGIT_W'(sum - 5'd10) : sum[DIGIT_W-1:0];

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - N-digit BCD score keeper, serial adder FSM, loss message and blanking; SCORE_KEEPER_HISCORE_EN adds a high-score register
module score_keeper
  import score_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter int MSG_BLINK = 0,
  parameter int BLINK_W   = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_game,
  input  logic                       add_valid,
  input  logic [DIGIT_W-1:0]         add_pts,
  output logic                       add_ready,
  input  logic                       game_over,
  input  logic                       show_hi,
  output logic [DIGIT_W*NDIGITS-1:0] digits,
  output logic [NDIGITS-1:0]         blank,
  output logic                       saturated,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NDIGITS);

  typedef logic [NDIGITS-1:0][DIGIT_W-1:0] bcd_t;

  state_e             state_q, state_d;
  bcd_t               score_q, score_d;
  logic [DIGIT_W-1:0] carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sat_q, sat_d;

  bcd_t               digits_q, disp_digits;
  logic [NDIGITS-1:0] blank_q, disp_blank;
  bcd_t               disp_src;
  logic               blink_off;

  logic [DIGIT_W-1:0] step_digit;
  logic               step_carry;
  logic               accept;

  assign add_ready = (state_q == ST_IDLE) & ~game_over & ~new_game;
  assign accept    = add_valid & add_ready;
  assign busy      = (state_q != ST_IDLE);
  assign saturated = sat_q;
  assign digits    = digits_q;
  assign blank     = blank_q;

  bcd_digit_step u_step (
    .digit_in  (score_q[idx_q]),
    .carry_in  (carry_q),
    .digit_out (step_digit),
    .carry_out (step_carry)
  );

  // FSM and score datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      carry_q <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
    end
  end

  // Next state: serial digit-by-digit add, saturation, new_game override
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADD;
          idx_d   = '0;
          // Once saturated an add is a single no-op cycle so the score never leaves all nines
          carry_d = sat_q ? '0 : clamp_pts(add_pts);
        end
      end
      ST_ADD: begin
        score_d[idx_q] = step_digit;
        if (!step_carry) begin
          state_d = ST_IDLE;
          carry_d = '0;
        end else if (idx_q == IDX_W'(NDIGITS - 1)) begin
          state_d = ST_SAT;
          carry_d = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          carry_d = DIGIT_W'(1);
        end
      end
      ST_SAT: begin
        for (int i = 0; i < NDIGITS; i++) begin
          score_d[i] = BCD_MAX;
        end
        sat_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (new_game) begin
      state_d = ST_IDLE;
      score_d = '0;
      carry_d = '0;
      idx_d   = '0;
      sat_d   = 1'b0;
    end
  end

`ifdef SCORE_KEEPER_HISCORE_EN
  bcd_t hiscore_q;
  logic hi_done_q;

  // Capture the score once per game_over episode, on its first idle cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore_q <= '0;
      hi_done_q <= 1'b0;
    end else if (!game_over) begin
      hi_done_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && !hi_done_q) begin
      hi_done_q <= 1'b1;
      // Packed BCD compares correctly as a plain unsigned number
      if (score_q > hiscore_q) begin
        hiscore_q <= score_q;
      end
    end
  end

  assign disp_src = show_hi ? hiscore_q : score_q;
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi;
  assign disp_src       = score_q;
`endif

  generate
    if (MSG_BLINK != 0) begin : g_blink
      logic [BLINK_W-1:0] blink_cnt_q;
      logic               blink_off_q;

      // Blink divider runs only while the loss message is up
      always_ff @(posedge clk) begin
        if (reset || !game_over) begin
          blink_cnt_q <= '0;
          blink_off_q <= 1'b0;
        end else begin
          blink_cnt_q <= blink_cnt_q + {{(BLINK_W-1){1'b0}}, 1'b1};
          if (&blink_cnt_q) begin
            blink_off_q <= ~blink_off_q;
          end
        end
      end

      assign blink_off = blink_off_q;
    end else begin : g_steady
      assign blink_off = 1'b0;
    end
  endgenerate

  // Display mux: loss message or score with leading-zero blanking
  always_comb begin
    logic all_zero;
    disp_digits = '0;
    disp_blank  = '0;
    all_zero    = 1'b1;
    if (game_over) begin
      disp_digits[0] = MSG_D;
      disp_digits[1] = MSG_1;
      disp_digits[2] = MSG_E;
      disp_digits[3] = MSG_F;
      for (int i = 4; i < NDIGITS; i++) begin
        disp_blank[i] = 1'b1;
      end
      disp_blank[3:0] = {4{blink_off}};
    end else begin
      disp_digits = disp_src;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
        all_zero      = all_zero & (disp_src[i] == '0);
        disp_blank[i] = all_zero;
      end
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
      blank_q  <= {{(NDIGITS-1){1'b1}}, 1'b0};
    end else begin
      digits_q <= disp_digits;
      blank_q  <= disp_blank;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed scoreboard bench for score_keeper
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        add_valid;
  logic [3:0]  add_pts;
  logic        add_ready;
  logic        game_over;
  logic        show_hi;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        saturated;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int model       = 0;
  bit model_sat   = 1'b0;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  b;
    logic        s;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  score_keeper #(.NDIGITS(4), .MSG_BLINK(0), .BLINK_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .new_game  (new_game),
    .add_valid (add_valid),
    .add_pts   (add_pts),
    .add_ready (add_ready),
    .game_over (game_over),
    .show_hi   (show_hi),
    .digits    (digits),
    .blank     (blank),
    .saturated (saturated),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] blank_of(input int v);
    logic [3:0] b;
    b    = 4'b0000;
    b[3] = (v < 1000);
    b[2] = (v < 100);
    b[1] = (v < 10);
    return b;
  endfunction

  task automatic do_add(input logic [3:0] pts, input int exp_busy);
    int   p;
    int   n;
    exp_t e;
    p = (pts > 4'd9) ? 9 : int'(pts);
    if (model + p > 9999) begin
      model     = 9999;
      model_sat = 1'b1;
    end else begin
      model = model + p;
    end
    sb.push_back('{d: to_bcd(model), b: blank_of(model), s: model_sat});
    add_valid = 1'b1;
    add_pts   = pts;
    check("add_ready_idle", add_ready, 1);
    tick;
    add_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick;
    end
    check("busy_bounded", (n < 20), 1);
    if (exp_busy >= 0) check("busy_cycles", n, exp_busy);
    tick;
    e = sb.pop_front();
    check("digits", digits, e.d);
    check("blank", blank, e.b);
    check("saturated", saturated, e.s);
  endtask

  task automatic start_new_game;
    new_game = 1'b1;
    tick;
    new_game  = 1'b0;
    model     = 0;
    model_sat = 1'b0;
    tick;
    check("ng_digits", digits, 16'h0000);
    check("ng_saturated", saturated, 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset     = 1'b0;
    model     = 0;
    model_sat = 1'b0;
    tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    new_game  = 1'b0;
    add_valid = 1'b0;
    add_pts   = 4'd0;
    game_over = 1'b0;
    show_hi   = 1'b0;
    do_reset;

    check("rst_digits", digits, 16'h0000);
    check("rst_blank", blank, 4'b1110);
    check("rst_add_ready", add_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_saturated", saturated, 0);

    do_add(4'hC, 1);

    start_new_game;
    for (int i = 0; i < 10; i++) do_add(4'd9, -1);
    do_add(4'd5, -1);
    check("score_0095", digits, 16'h0095);
    do_add(4'd7, 3);
    check("score_0102", digits, 16'h0102);
    check("blank_0102", blank, 4'b1000);

    do_add(4'd0, 1);

    // new_game while an add is in flight
    add_valid = 1'b1;
    add_pts   = 4'd9;
    tick;
    add_valid = 1'b0;
    check("midadd_busy", busy, 1);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    model    = 0;
    check("midadd_idle", busy, 0);
    check("midadd_sat", saturated, 0);
    tick;
    check("midadd_digits", digits, 16'h0000);

    for (int i = 0; i < 1110; i++) do_add(4'd9, -1);
    do_add(4'd8, -1);
    check("score_9998", digits, 16'h9998);
    do_add(4'd5, 5);
    check("sat_flag", saturated, 1);
    do_add(4'd3, 1);
    check("sat_hold", digits, 16'h9999);

    game_over = 1'b1;
    tick;
    tick;
    check("go_digits", digits, 16'hFE1D);
    check("go_blank", blank, 4'b0000);
    check("go_add_ready", add_ready, 0);
    add_valid = 1'b1;
    add_pts   = 4'd4;
    tick;
    add_valid = 1'b0;
    check("go_add_ignored", busy, 0);
    game_over = 1'b0;
    tick;
    tick;
    check("go_after_digits", digits, to_bcd(model));

    start_new_game;

`ifdef SCORE_KEEPER_HISCORE_EN
    do_reset;
    for (int i = 0; i < 13; i++) do_add(4'd9, -1);
    do_add(4'd3, -1);
    game_over = 1'b1;
    tick;
    tick;
    tick;
    game_over = 1'b0;
    tick;
    start_new_game;
    for (int i = 0; i < 5; i++) do_add(4'd9, -1);
    do_add(4'd5, -1);
    game_over = 1'b1;
    tick;
    tick;
    game_over = 1'b0;
    show_hi   = 1'b1;
    tick;
    tick;
    check("hi_digits", digits, 16'h0120);
    check("hi_blank", blank, 4'b1000);
    show_hi = 1'b0;
    tick;
    tick;
    check("hi_off_digits", digits, 16'h0050);
`else
    do_add(4'd6, 1);
    show_hi = 1'b1;
    tick;
    tick;
    check("show_hi_ignored", digits, to_bcd(model));
    show_hi = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
